// File: rtl/isoiec7816_tx_sequencer_if.sv
// isoiec7816_tx_sequencer_if
// Groups the buffer-read port and the transmitter port of the ISO/IEC 7816
// block-transmit sequencer.
//   rd_en / rd_addr   : buffer read strobe and byte address (sequencer -> buffer)
//   rd_data           : buffer byte, valid exactly one cycle after rd_en
//   tx_char / tx_load : registered character and one-cycle load pulse
//   tx_idle           : transmitter can accept a load
//   tx_transmitted    : transmitter end-of-character pulse
//   err_strobe        : receiver signalled an error on the current character
//
// Handshake: tx_load acts as "valid" and tx_idle as "ready". A character is
// handed over only in a cycle where both are high. tx_load is never raised
// while tx_idle is low, and tx_char is stable for at least one cycle before
// and during the load.
interface isoiec7816_tx_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        tx_char;
    logic              tx_load;
    logic              tx_idle;
    logic              tx_transmitted;
    logic              err_strobe;

    modport master (
        output rd_en, rd_addr, tx_char, tx_load,
        input  rd_data, tx_idle, tx_transmitted, err_strobe
    );

    modport slave (
        input  rd_en, rd_addr, tx_char, tx_load,
        output rd_data, tx_idle, tx_transmitted, err_strobe
    );
endinterface

// File: rtl/isoiec7816_tx_sequencer.sv
// isoiec7816_tx_sequencer
// Block-transmit controller for an ISO/IEC 7816 character transmitter. It
// fetches a block of bytes from a synchronous buffer and hands them to the
// transmitter one at a time. If the receiver flags a parity error (T=0
// character repetition), the same character is resent, up to MAX_RETRY times.
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   start, length      : block request (pulse) and byte count (0 is legal)
//   abort              : return to IDLE from any state, with no done/fail pulse
//   bus (master)       : buffer read port and transmitter port
//   busy               : high in every state except IDLE
//   done / fail        : one-cycle completion / retry-exhausted pulses
//   fail_index         : index of the failing byte, held until the next start
//   retries            : retry count for the current character
//   state_dbg          : current FSM state
module isoiec7816_tx_sequencer #(
    parameter int MAX_RETRY = 3,
    parameter int ADDR_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W:0]           length,
    input  logic                      abort,
    isoiec7816_tx_sequencer_if.master bus,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [ADDR_W-1:0]         fail_index,
    output logic [3:0]                retries,
    output logic [2:0]                state_dbg
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        SETUP   = 3'd3,
        LOAD    = 3'd4,
        SEND    = 3'd5,
        RESULT  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [3:0]        retries_q, retries_d;
    logic [7:0]        tx_char_q, tx_char_d;
    logic              err_latched_q, err_latched_d;
    logic [ADDR_W-1:0] fail_index_q, fail_index_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            remaining_q   <= '0;
            retries_q     <= '0;
            tx_char_q     <= 8'h00;
            err_latched_q <= 1'b0;
            fail_index_q  <= '0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            remaining_q   <= remaining_d;
            retries_q     <= retries_d;
            tx_char_q     <= tx_char_d;
            err_latched_q <= err_latched_d;
            fail_index_q  <= fail_index_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        remaining_d   = remaining_q;
        retries_d     = retries_q;
        tx_char_d     = tx_char_q;
        err_latched_d = err_latched_q;
        fail_index_d  = fail_index_q;
        done_d        = 1'b0;
        fail_d        = 1'b0;

        if (abort) begin
            // Abort beats a simultaneous start. A character already on the
            // line finishes there; its tx_transmitted is then seen in IDLE
            // and ignored.
            state_d       = IDLE;
            err_latched_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fail_index_d = '0;
                        if (length == '0) begin
                            done_d = 1'b1;
                        end else begin
                            idx_d       = '0;
                            remaining_d = length;
                            retries_d   = '0;
                            state_d     = FETCH;
                        end
                    end
                end
                FETCH:   state_d = CAPTURE;
                CAPTURE: begin
                    tx_char_d = bus.rd_data;
                    state_d   = SETUP;
                end
                SETUP:   state_d = LOAD;
                LOAD: begin
                    if (bus.tx_idle) begin
                        err_latched_d = 1'b0;
                        state_d       = SEND;
                    end
                end
                SEND: begin
                    // Sticky. A strobe in the same cycle as tx_transmitted
                    // still reaches RESULT through the flop.
                    if (bus.err_strobe) err_latched_d = 1'b1;
                    if (bus.tx_transmitted) state_d = RESULT;
                end
                RESULT: begin
                    if (err_latched_q) begin
                        if (retries_q < 4'(MAX_RETRY)) begin
                            // Resend the held tx_char with no refetch.
                            retries_d = retries_q + 4'd1;
                            state_d   = LOAD;
                        end else begin
                            fail_d       = 1'b1;
                            fail_index_d = idx_q;
                            state_d      = IDLE;
                        end
                    end else if (remaining_q == (ADDR_W+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d       = idx_q + ADDR_W'(1);
                        remaining_d = remaining_q - (ADDR_W+1)'(1);
                        retries_d   = '0;
                        state_d     = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.rd_en   = (state_q == FETCH);
        bus.rd_addr = idx_q;
        bus.tx_char = tx_char_q;
        // Gated by abort so that no new character leaves while we abandon
        // the block.
        bus.tx_load = (state_q == LOAD) && bus.tx_idle && !abort;
        busy        = (state_q != IDLE);
        done        = done_q;
        fail        = fail_q;
        fail_index  = fail_index_q;
        retries     = retries_q;
        state_dbg   = state_q;
    end
endmodule

// File: tb/tb_isoiec7816_tx_sequencer.sv
// tb_isoiec7816_tx_sequencer
// Directed bench for isoiec7816_tx_sequencer. The bench contains a
// synchronous buffer model and a simple transmitter model. The transmitter
// model goes busy for four cycles after each load. It can inject err_strobe
// per load number, either in the middle of SEND or together with
// tx_transmitted. Every load is recorded in the scoreboard as {retries, tx_char}.
module tb_isoiec7816_tx_sequencer;
    localparam int ADDR_W    = 8;
    localparam int MAX_RETRY = 3;
    localparam int W         = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_index;
    logic [3:0]        retries;
    logic [2:0]        state_dbg;

    isoiec7816_tx_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

    isoiec7816_tx_sequencer #(
        .MAX_RETRY (MAX_RETRY),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .length     (length),
        .abort      (abort),
        .bus        (bus_if),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_index (fail_index),
        .retries    (retries),
        .state_dbg  (state_dbg)
    );

    // Clock / reset block
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int n_load;
    int n_rd;
    int n_done;
    int n_failp;
    int load_num;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [7:0]   mem [0:255];
    logic         line_idle;
    logic         hold_low;
    logic [15:0]  err_loads;
    bit           err_same;

    assign bus_if.tx_idle = line_idle && !hold_low;

    // Synchronous buffer: data one cycle after rd_en
    always @(posedge clock) begin
        if (bus_if.rd_en === 1'b1) bus_if.rd_data <= mem[bus_if.rd_addr];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        obs_q.delete();
        exp_q.delete();
        n_load    = 0;
        n_rd      = 0;
        n_done    = 0;
        n_failp   = 0;
        load_num  = 0;
        err_loads = '0;
        err_same  = 1'b0;
    endtask

    task automatic compare_sb(input string tag);
        chk({tag, "_load_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk({tag, "_load"}, obs_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic start_block(input logic [ADDR_W:0] len);
        step();
        start  = 1'b1;
        length = len;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy !== 1'b0 && n < max);
        chk({tag, "_busy_falls"}, busy, 0);
    endtask

    task automatic settle();
        repeat (4) step();
    endtask

    // Monitor
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (bus_if.tx_load === 1'b1) begin
                obs_q.push_back({retries, bus_if.tx_char});
                n_load++;
                chk("load_while_tx_busy", bus_if.tx_idle, 1);
            end
            if (bus_if.rd_en === 1'b1) n_rd++;
            if (done === 1'b1) begin
                n_done++;
                chk("done_with_busy", busy, 0);
            end
            if (fail === 1'b1) begin
                n_failp++;
                chk("fail_with_busy", busy, 0);
            end
        end
    end

    // Transmitter model
    initial begin
        bit e;
        bus_if.err_strobe     = 1'b0;
        bus_if.tx_transmitted = 1'b0;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && bus_if.tx_load === 1'b1) begin
                e = (load_num < 16) ? err_loads[load_num] : 1'b0;
                load_num++;
                step();
                line_idle = 1'b0;
                step();
                step();
                bus_if.err_strobe = e && !err_same;
                step();
                bus_if.err_strobe     = e && err_same;
                bus_if.tx_transmitted = 1'b1;
                step();
                bus_if.err_strobe     = 1'b0;
                bus_if.tx_transmitted = 1'b0;
                line_idle             = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int bad;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        length    = '0;
        line_idle = 1'b1;
        hold_low  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[0] = 8'h3B;
        mem[1] = 8'h95;
        mem[2] = 8'h11;
        mem[3] = 8'hA5;
        mem[4] = 8'h5A;
        clear_sb();

        // Reset values
        repeat (3) step();
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_rd_en", bus_if.rd_en, 0);
        chk("rst_tx_load", bus_if.tx_load, 0);
        chk("rst_rd_addr", bus_if.rd_addr, 0);
        chk("rst_fail_index", fail_index, 0);
        chk("rst_retries", retries, 0);
        chk("rst_tx_char", bus_if.tx_char, 8'h00);
        chk("rst_state", state_dbg, 0);
        step();
        reset = 1'b0;

        // T1: three bytes, no errors, with cycle-exact latency checks
        clear_sb();
        step();
        start  = 1'b1;
        length = 9'd3;
        @(negedge clock);
        chk("t1_c0_busy", busy, 0);
        chk("t1_c0_rd_en", bus_if.rd_en, 0);
        step();
        start = 1'b0;
        @(negedge clock);
        chk("t1_c1_rd_en", bus_if.rd_en, 1);
        chk("t1_c1_rd_addr", bus_if.rd_addr, 0);
        chk("t1_c1_busy", busy, 1);
        step();
        @(negedge clock);
        chk("t1_c2_rd_en", bus_if.rd_en, 0);
        step();
        @(negedge clock);
        chk("t1_c3_tx_char", bus_if.tx_char, 8'h3B);
        chk("t1_c3_tx_load", bus_if.tx_load, 0);
        step();
        @(negedge clock);
        chk("t1_c4_tx_load", bus_if.tx_load, 1);
        wait_idle("t1", 200);
        settle();
        exp_q.push_back(12'h03B);
        exp_q.push_back(12'h095);
        exp_q.push_back(12'h011);
        compare_sb("t1");
        chk("t1_done_count", n_done, 1);
        chk("t1_fail_count", n_failp, 0);
        chk("t1_rd_count", n_rd, 3);

        // T2: one error on the first character, mid-SEND
        clear_sb();
        err_loads[0] = 1'b1;
        start_block(9'd2);
        wait_idle("t2", 300);
        settle();
        exp_q.push_back(12'h03B);
        exp_q.push_back(12'h13B);
        exp_q.push_back(12'h095);
        compare_sb("t2");
        chk("t2_done_count", n_done, 1);
        chk("t2_fail_count", n_failp, 0);
        chk("t2_rd_count", n_rd, 2);

        // T3: every attempt of byte 1 errs (strobe with tx_transmitted)
        clear_sb();
        err_same     = 1'b1;
        err_loads[1] = 1'b1;
        err_loads[2] = 1'b1;
        err_loads[3] = 1'b1;
        err_loads[4] = 1'b1;
        start_block(9'd3);
        wait_idle("t3", 400);
        settle();
        exp_q.push_back(12'h03B);
        exp_q.push_back(12'h095);
        exp_q.push_back(12'h195);
        exp_q.push_back(12'h295);
        exp_q.push_back(12'h395);
        compare_sb("t3");
        chk("t3_fail_count", n_failp, 1);
        chk("t3_done_count", n_done, 0);
        chk("t3_fail_index", fail_index, 1);
        chk("t3_rd_count", n_rd, 2);
        chk("t3_busy", busy, 0);

        // T4: zero-length block
        clear_sb();
        step();
        start  = 1'b1;
        length = 9'd0;
        @(negedge clock);
        chk("t4_c0_done", done, 0);
        step();
        start = 1'b0;
        @(negedge clock);
        chk("t4_c1_done", done, 1);
        chk("t4_c1_busy", busy, 0);
        step();
        @(negedge clock);
        chk("t4_c2_done", done, 0);
        settle();
        chk("t4_rd_count", n_rd, 0);
        chk("t4_load_count", n_load, 0);
        chk("t4_done_count", n_done, 1);

        // T5: abort during SEND of the second byte of five
        clear_sb();
        start_block(9'd5);
        seen = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            @(negedge clock);
            if (bus_if.tx_load === 1'b1) seen++;
        end
        chk("t5_second_load_seen", seen, 2);
        step();
        abort = 1'b1;
        @(negedge clock);
        chk("t5_in_send", state_dbg, 5);
        step();
        abort = 1'b0;
        @(negedge clock);
        chk("t5_busy_after_abort", busy, 0);
        chk("t5_state_after_abort", state_dbg, 0);
        repeat (10) step();
        chk("t5_done_count", n_done, 0);
        chk("t5_fail_count", n_failp, 0);
        chk("t5_load_count", n_load, 2);
        chk("t5_rd_count", n_rd, 2);
        chk("t5_busy_late", busy, 0);
        clear_sb();
        start_block(9'd1);
        @(negedge clock);
        chk("t5_restart_rd_en", bus_if.rd_en, 1);
        chk("t5_restart_rd_addr", bus_if.rd_addr, 0);
        wait_idle("t5", 200);
        settle();
        exp_q.push_back(12'h03B);
        compare_sb("t5");
        chk("t5_restart_done", n_done, 1);

        // T6: transmitter stalled for 50 cycles; start while busy is ignored
        clear_sb();
        hold_low = 1'b1;
        start_block(9'd2);
        repeat (3) step();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            start  = (i == 20);
            length = 9'd5;
            @(negedge clock);
            if (bus_if.tx_load !== 1'b0 || bus_if.tx_char !== 8'h3B || state_dbg !== 3'd4) bad++;
        end
        chk("t6_stall_violations", bad, 0);
        step();
        start    = 1'b0;
        hold_low = 1'b0;
        @(negedge clock);
        chk("t6_load_on_release", bus_if.tx_load, 1);
        wait_idle("t6", 200);
        settle();
        exp_q.push_back(12'h03B);
        exp_q.push_back(12'h095);
        compare_sb("t6");
        chk("t6_done_count", n_done, 1);
        chk("t6_rd_count", n_rd, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
